// File: rtl/axi_tester_pkg.sv
// Shared AXI4 encodings and the tester state machine encoding for the cosim
// memory-path burst tester.
package axi_tester_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    // Bufferable + modifiable, unprivileged secure data access.
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

endpackage

// File: rtl/axi_tester_if.sv
// AXI4 full channel bundle between the burst tester (master) and the RAM
// slave.
interface axi_tester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_tester_pattern.sv
// Counter pattern generator: loads a seed, then steps by one per advance.
// One instance feeds write data, another produces the expected read data.
module axi_tester_pattern #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] value_o
);

    logic [DATA_WIDTH-1:0] value_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= seed_i;
        end else if (advance_i) begin
            value_q <= value_q + DATA_WIDTH'(1);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 burst traffic master: writes an incrementing pattern burst, reads the
// same region back, and reports pass/fail with a saturating error count.
module axi_mem_tester
    import axi_tester_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] TX_ID      = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            burst_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  config_err,
    output logic [7:0]            err_count,
    axi_tester_if.master          m_axi
);

    localparam int SIZE_LOG = $clog2(STRB_WIDTH);
    localparam int CHK_W    = ADDR_WIDTH + SIZE_LOG + 10;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [7:0]            err_q;
    logic                  busy_q, done_q, pass_q, cfg_q;
    logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [CHK_W-1:0]      cmd_end;
    logic                  cmd_ok, accept, w_hs, r_hs, b_bad, r_bad;
    logic [7:0]            err_r;
    logic [DATA_WIDTH-1:0] wr_val, rd_val;

    // Range check is done at a width that cannot overflow for any len/addr.
    assign cmd_addr = base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    assign cmd_end  = CHK_W'(cmd_addr) + ((CHK_W'(burst_len) + CHK_W'(1)) << SIZE_LOG);
    assign cmd_ok   = (cmd_end <= (CHK_W'(1) << ADDR_WIDTH));

    assign accept = (state_q == ST_IDLE) && start && cmd_ok;
    assign w_hs   = (state_q == ST_W) && wvalid_q && m_axi.wready;
    assign r_hs   = (state_q == ST_R) && rready_q && m_axi.rvalid;

    assign b_bad = (m_axi.bresp != RESP_OKAY) || (m_axi.bid != TX_ID);
    assign r_bad = (m_axi.rdata != rd_val) || (m_axi.rresp != RESP_OKAY) ||
                   (m_axi.rid != TX_ID) || (m_axi.rlast != (beat_q == len_q));
    assign err_r = r_bad ? sat_inc(err_q) : err_q;

    axi_tester_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept),
        .seed_i    (seed),
        .advance_i (w_hs),
        .value_o   (wr_val)
    );

    axi_tester_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pat (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept),
        .seed_i    (seed),
        .advance_i (r_hs),
        .value_o   (rd_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cfg_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err_q  <= '0;
                        pass_q <= 1'b0;
                        if (cmd_ok) begin
                            addr_q    <= cmd_addr;
                            len_q     <= burst_len;
                            beat_q    <= '0;
                            cfg_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            cfg_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_AW: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (len_q == 8'd0);
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (m_axi.wready) begin
                        if (beat_q == len_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            beat_q   <= '0;
                            state_q  <= ST_B;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            wlast_q <= ((beat_q + 8'd1) == len_q);
                        end
                    end
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        if (b_bad) begin
                            err_q <= sat_inc(err_q);
                        end
                        bready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    // The beat count, not rlast, ends the read burst.
                    if (m_axi.rvalid) begin
                        err_q <= err_r;
                        if (beat_q == len_q) begin
                            rready_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (err_r == 8'd0);
                            state_q  <= ST_DONE;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign config_err = cfg_q;
    assign err_count  = err_q;

    assign m_axi.awid    = TX_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = 3'(SIZE_LOG);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE_DEFAULT;
    assign m_axi.awprot  = AXI_PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata  = wr_val;
    assign m_axi.wstrb  = '1;
    assign m_axi.wlast  = wlast_q;
    assign m_axi.wvalid = wvalid_q;

    assign m_axi.bready = bready_q;

    assign m_axi.arid    = TX_ID;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = 3'(SIZE_LOG);
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE_DEFAULT;
    assign m_axi.arprot  = AXI_PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.rready = rready_q;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Directed bench for axi_mem_tester with a small AXI4 RAM slave model whose
// stalls and response faults are steered from the stimulus sequence.
module tb_axi_mem_tester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  burst_len;
    logic [31:0] seed;
    logic        busy, done, pass, config_err;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    axi_tester_if m_axi ();

    axi_mem_tester dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .burst_len  (burst_len),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .config_err (config_err),
        .err_count  (err_count),
        .m_axi      (m_axi)
    );

    always #5 clk = ~clk;

    // Slave model knobs.
    int aw_stall = 0;
    bit w_rand = 1'b0;
    bit ar_rand = 1'b0;
    int corrupt_beat = -1;
    int resp_beat = -1;

    logic [31:0] mem [64];
    logic [7:0]  aw_cnt, wptr, rptr, rbeat, rlen, bid_q, arid_q;
    logic        wready_r, arready_r, bvalid_r, rvalid_r;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt    <= '0;
            wready_r  <= 1'b0;
            arready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            rbeat     <= '0;
            rlen      <= '0;
            bid_q     <= '0;
            arid_q    <= '0;
        end else begin
            aw_cnt    <= (m_axi.awvalid && !m_axi.awready) ? aw_cnt + 8'd1 : 8'd0;
            wready_r  <= w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            arready_r <= ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axi.awvalid && m_axi.awready) begin
                wptr  <= m_axi.awaddr;
                bid_q <= m_axi.awid;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                mem[wptr[7:2]] <= m_axi.wdata;
                wptr <= wptr + 8'd4;
                if (m_axi.wlast) bvalid_r <= 1'b1;
            end
            if (bvalid_r && m_axi.bready) bvalid_r <= 1'b0;
            if (m_axi.arvalid && m_axi.arready) begin
                rptr     <= m_axi.araddr;
                rlen     <= m_axi.arlen;
                rbeat    <= '0;
                arid_q   <= m_axi.arid;
                rvalid_r <= 1'b1;
            end
            if (rvalid_r && m_axi.rready) begin
                if (rbeat == rlen) begin
                    rvalid_r <= 1'b0;
                end else begin
                    rbeat <= rbeat + 8'd1;
                    rptr  <= rptr + 8'd4;
                end
            end
        end
    end

    assign m_axi.awready = m_axi.awvalid && (int'(aw_cnt) >= aw_stall);
    assign m_axi.wready  = wready_r;
    assign m_axi.bid     = bid_q;
    assign m_axi.bresp   = 2'b00;
    assign m_axi.bvalid  = bvalid_r;
    assign m_axi.arready = arready_r;
    assign m_axi.rid     = arid_q;
    assign m_axi.rdata   = mem[rptr[7:2]] ^ ((int'(rbeat) == corrupt_beat) ? 32'h0000_0100 : 32'h0);
    assign m_axi.rresp   = (int'(rbeat) == resp_beat) ? 2'b10 : 2'b00;
    assign m_axi.rlast   = (rbeat == rlen);
    assign m_axi.rvalid  = rvalid_r;

    // Bus monitor: logs W beats, AW handshakes and valid activity.
    int          cyc = 0;
    int          wn = 0;
    logic [31:0] wlog [256];
    logic        wlastlog [256];
    int          wcyc [256];
    int          aw_hs_cyc = 0;
    logic [7:0]  aw_addr_last = '0;
    int          axv_cnt = 0;
    int          awv_cnt = 0;
    int          aw_unstable = 0;
    bit          aw_hold = 1'b0;
    logic [7:0]  aw_hold_addr = '0;

    always @(posedge clk) begin
        cyc++;
        if (aw_hold && m_axi.awvalid && (m_axi.awaddr !== aw_hold_addr)) aw_unstable++;
        aw_hold      = m_axi.awvalid && !m_axi.awready;
        aw_hold_addr = m_axi.awaddr;
        if (m_axi.awvalid || m_axi.arvalid) axv_cnt++;
        if (m_axi.awvalid) awv_cnt++;
        if (m_axi.awvalid && m_axi.awready) begin
            aw_hs_cyc    = cyc;
            aw_addr_last = m_axi.awaddr;
        end
        if (m_axi.wvalid && m_axi.wready) begin
            wlog[wn & 255]     = m_axi.wdata;
            wlastlog[wn & 255] = m_axi.wlast;
            wcyc[wn & 255]     = cyc;
            wn++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Results captured by run_cmd.
    int   edges, wbase, axv_base, awv_base;
    logic busy_n1, awv_n1, pass_d, cfg_d, busy_d;
    logic [7:0] err_d;

    task automatic issue(input logic [7:0] b, input logic [7:0] l, input logic [31:0] s);
        @(negedge clk);
        base_addr = b;
        burst_len = l;
        seed      = s;
        start     = 1'b1;
        wbase     = wn;
        axv_base  = axv_cnt;
        awv_base  = awv_cnt;
        @(negedge clk);
        start   = 1'b0;
        busy_n1 = busy;
        awv_n1  = m_axi.awvalid;
    endtask

    task automatic run_cmd(input logic [7:0] b, input logic [7:0] l, input logic [31:0] s);
        issue(b, l, s);
        edges = 1;
        while (!done && edges < 3000) begin
            @(negedge clk);
            edges++;
        end
        chk("done_seen", done, 1'b1);
        pass_d = pass;
        cfg_d  = config_err;
        err_d  = err_count;
        busy_d = busy;
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        burst_len = '0;
        seed      = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_cfg", config_err, 1'b0);
        chk("rst_err", err_count, 8'd0);
        chk("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}, 5'b0);
        chk("rst_awaddr", m_axi.awaddr, 8'h00);
        chk("rst_wdata", m_axi.wdata, 32'h0);
        chk("const_aw", {m_axi.awsize, m_axi.awburst, m_axi.awlock, m_axi.awcache, m_axi.awprot},
            {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        chk("const_ar", {m_axi.arsize, m_axi.arburst, m_axi.arlock, m_axi.arcache, m_axi.arprot},
            {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
        chk("const_id_strb", {m_axi.awid, m_axi.arid, m_axi.wstrb}, {8'h5A, 8'h5A, 4'hF});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single beat, minimum latency
        run_cmd(8'h00, 8'd0, 32'h1000_0000);
        chk("t1_busy_n1", busy_n1, 1'b1);
        chk("t1_awvalid_n1", awv_n1, 1'b1);
        chk("t1_latency_cycles", edges + 1, 7);
        chk("t1_beats", wn - wbase, 1);
        chk("t1_wdata", wlog[wbase & 255], 32'h1000_0000);
        chk("t1_wlast", wlastlog[wbase & 255], 1'b1);
        chk("t1_result", {pass_d, cfg_d, err_d, busy_d}, {1'b1, 1'b0, 8'd0, 1'b0});
        @(negedge clk);
        chk("t1_pass_hold", {pass, done}, 2'b10);

        // 2: 16-beat burst at 0x40
        run_cmd(8'h40, 8'd15, 32'hA5A5_0000);
        chk("t2_awaddr", aw_addr_last, 8'h40);
        chk("t2_beats", wn - wbase, 16);
        chk("t2_last_beat", wlog[(wbase + 15) & 255], 32'hA5A5_000F);
        chk("t2_wlast_pos", {wlastlog[(wbase + 14) & 255], wlastlog[(wbase + 15) & 255]}, 2'b01);
        chk("t2_aw_to_w", wcyc[wbase & 255] - aw_hs_cyc, 1);
        chk("t2_back_to_back", wcyc[(wbase + 15) & 255] - wcyc[wbase & 255], 15);
        chk("t2_mem_first", mem[16], 32'hA5A5_0000);
        chk("t2_mem_last", mem[31], 32'hA5A5_000F);
        chk("t2_result", {pass_d, cfg_d, err_d}, {1'b1, 1'b0, 8'd0});

        // 3: top-of-range accept, then reject
        run_cmd(8'hF0, 8'd3, 32'h0000_0003);
        chk("t3a_result", {pass_d, cfg_d, err_d}, {1'b1, 1'b0, 8'd0});
        chk("t3a_mem_top", mem[63], 32'h0000_0006);
        run_cmd(8'hF4, 8'd3, 32'h0000_0003);
        chk("t3b_latency", edges, 1);
        chk("t3b_busy_n1", busy_n1, 1'b0);
        chk("t3b_result", {pass_d, cfg_d, err_d}, {1'b0, 1'b1, 8'd0});
        chk("t3b_no_axi", axv_cnt - axv_base, 0);

        // 4: stalled AW, random W/AR gaps, unaligned base
        aw_stall = 5;
        w_rand   = 1'b1;
        ar_rand  = 1'b1;
        run_cmd(8'h13, 8'd7, 32'hDEAD_BEE0);
        chk("t4_awaddr_aligned", aw_addr_last, 8'h10);
        chk("t4_aw_stable", aw_unstable, 0);
        chk("t4_aw_valid_cycles", awv_cnt - awv_base, 6);
        chk("t4_beats", wn - wbase, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_beat%0d", k), wlog[(wbase + k) & 255], 32'hDEAD_BEE0 + 32'(k));
        end
        chk("t4_result", {pass_d, cfg_d, err_d}, {1'b1, 1'b0, 8'd0});
        aw_stall = 0;
        w_rand   = 1'b0;
        ar_rand  = 1'b0;

        // 5: corrupted data on beat 2, SLVERR on beat 5
        corrupt_beat = 2;
        resp_beat    = 5;
        run_cmd(8'h80, 8'd7, 32'h0000_0055);
        chk("t5_result", {pass_d, cfg_d, err_d}, {1'b0, 1'b0, 8'd2});
        corrupt_beat = -1;
        resp_beat    = -1;

        // 6: reset during W beat 3, then a clean run
        issue(8'h00, 8'd7, 32'h0000_0077);
        guard = 0;
        while ((wn - wbase) < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_reached_beat3", {m_axi.wvalid, 32'(wn - wbase)} == {1'b1, 32'd3}, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_after_rst", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, busy},
            6'b0);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(8'h20, 8'd3, 32'h0000_0900);
        chk("t6_beat0", wlog[wbase & 255], 32'h0000_0900);
        chk("t6_result", {pass_d, cfg_d, err_d}, {1'b1, 1'b0, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mem_tester.md
# axi_mem_tester

AXI4 burst traffic master for the cosim memory path. It sits directly upstream of the AXI4 RAM slave, and drives the slave's full AXI4 port set. On each start command it performs one INCR write burst of a deterministic pattern, then one read burst of the same region. It checks every read beat and reports pass/fail plus an error count to the SystemC side.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width.
- ADDR_WIDTH, 8, AXI byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; power of two.
- ID_WIDTH, 8, AXI ID width.
- TX_ID, 8'h5A, ID driven on AW/AR and expected on B/R.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  burst start byte address.
- burst_len  in  8  AXI len (beats-1).
- seed  in  DATA_WIDTH  pattern seed.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result; valid from the done pulse until the next accepted start.
- config_err  out  1  command rejected; same validity as pass.
- err_count  out  8  saturating error count.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}/awready  AXI4 write address channel.
- m_axi_w{data,strb,last,valid}/wready  AXI4 write data channel.
- m_axi_b{id,resp,valid}/bready  AXI4 write response channel.
- m_axi_ar{...}/arready, m_axi_r{id,data,resp,last,valid}/rready  AXI4 read channels, same field set as AW/W/B.

## Operation
- Constant fields: size = log2(STRB_WIDTH), burst = INCR (2'b01), lock = 0, cache = 4'b0011, prot = 3'b000, wstrb = all ones.
- Address alignment: addr = base_addr with low log2(STRB_WIDTH) bits forced to 0.
- Range check: if addr + (burst_len+1)*STRB_WIDTH > 2**ADDR_WIDTH, the command is rejected.
  - No AXI traffic is issued.
  - Next cycle: done=1, config_err=1, pass=0, err_count=0.
- Pattern: beat k carries seed + k, modulo 2**DATA_WIDTH. The write and check paths use identical generators.
- States: IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE. A rejected command goes IDLE -> DONE.
  - AW: awvalid=1 until awready; then go to W.
  - W: wvalid=1; one beat per wvalid&wready cycle; wlast=1 on beat burst_len; after the last handshake go to B.
  - B: bready=1; on bvalid, err +1 if bresp!=0 or bid!=TX_ID; then go to AR.
  - AR: same address and len as AW; arvalid=1 until arready; then go to R.
  - R: rready=1; each beat adds at most +1 error, for any of:
    - rdata != expected;
    - rresp != 0;
    - rid != TX_ID;
    - rlast != (k == burst_len).
  - R exits after beat burst_len regardless of rlast.
  - DONE: done=1, pass=(err_count==0); go to IDLE.
- err_count clears on an accepted start and saturates at 255.
- start while busy is ignored.

## Timing
- Reset values: every valid/ready output = 0, busy = 0, done = 0, pass = 0, config_err = 0, err_count = 0. Address/data outputs are 0.
- start accepted in cycle N: busy=1 and awvalid=1 in N+1.
- wvalid asserts the cycle after the AW handshake. Consecutive W beats are back-to-back when wready stays high (zero bubbles).
- arvalid asserts the cycle after the B handshake.
- done asserts the cycle after the final R beat; busy drops in the same cycle done asserts.
- Handshake rules:
  - Payload is stable while valid is high and ready is low.
  - valid never drops before its handshake completes.
  - W is never issued before the AW handshake.
- Reset mid-operation: the cycle after rst_n is sampled low, all valids/readies = 0 and state = IDLE. The downstream slave shares the reset.
- Minimum latency, len=0, zero-wait slave: start -> done = 7 cycles.

## Structure
- Package axi_tester_pkg holds:
  - burst codes FIXED/INCR/WRAP;
  - resp codes OKAY/EXOKAY/SLVERR/DECERR;
  - the tester state enum.
- Sub-module axi_tester_pattern: counter-based generator with seed load, advance, and current value outputs. It is instantiated twice, once for write data and once for expected read data.

## Test plan
1. base 0x00, len 0, seed 0x1000_0000 -> single W beat 0x1000_0000 with wlast=1; R matches; done, pass=1, err_count=0.
2. base 0x40, len 15, seed 0xA5A5_0000 -> 16 beats covering 0x40..0x7C, last beat 0xA5A5_000F; pass=1.
3. base 0xF0, len 3 -> accepted, ends exactly at 0x100, pass=1. base 0xF4, len 3 -> config_err=1, pass=0, no AW/AR valid ever asserted.
4. Slave BFM holds awready low 5 cycles and inserts random wready/arready gaps -> awaddr stable while stalled, beat sequence unchanged, pass=1.
5. BFM corrupts rdata on beat 2 and returns rresp=2'b10 on beat 5 (len 7) -> err_count=2, pass=0.
6. rst_n low for 1 cycle during W beat 3 -> next cycle all valids 0, busy 0; a following start completes with pass=1.
